pagerank_sweep_ctrl: RTL and testbench
======================================

Name: pagerank_sweep_ctrl

Overview:
- Sequences one PageRank damping sweep over the 21-bit rank register file.
- For each node index 0..NODES-1, performs read-modify-write: new = sat((old * damping) >> FRAC + base).
- Arbitrates register-file access between the sweep engine and a host port. Host accesses are allowed only while idle.
- Sits between the top-level iteration control/host and the rank register file, and drives all of that file's control pins.

Parameters:
- WIDTH, 21, rank word width (unsigned fixed point).
- ADDWIDTH, 5, register file address width.
- NODES, 32, entries swept per pass; 1 <= NODES <= 2**ADDWIDTH.
- FRAC, 16, fractional bits of damping/rank format.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  sweep request pulse; sampled only in IDLE.
- damping  input  WIDTH  damping factor, Q(WIDTH-FRAC).FRAC; captured when start is accepted.
- base  input  WIDTH  additive term (1-d)/N; captured when start is accepted.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- sat  output  1  sticky; set if any node saturated during the last sweep, cleared on start accept.
- host_req  input  1  host access request; level, held until granted.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  ADDWIDTH  host address.
- host_wdata  input  WIDTH  host write data.
- host_gnt  output  1  combinational grant.
- host_rvalid  output  1  pulse one cycle after a granted read; host_rdata is valid then.
- host_rdata  output  WIDTH  equals rf_dataOut.
- rf_writeEnable  output  1  to register file.
- rf_readEnable  output  1  to register file.
- rf_dest  output  ADDWIDTH  to register file.
- rf_source  output  ADDWIDTH  to register file.
- rf_dataIn  output  WIDTH  to register file.
- rf_dataOut  input  WIDTH  from register file. Registered: valid the cycle after rf_readEnable, and 0 otherwise.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; index = 0.
  - busy, done, sat, host_rvalid, and all rf_* outputs go to 0. The captured damping/base registers go to 0.
  - A reset mid-sweep abandons the sweep. Entries already written keep their new values; this block does not clear the register file.
- States: IDLE, RD, CALC, WR.
- IDLE:
  - If start=1, capture damping/base, clear sat, set index = 0, go to RD, and assert busy from the next cycle.
  - start has priority over host_req: host_gnt=0 in that cycle.
- RD: rf_readEnable=1, rf_source=index → CALC.
- CALC:
  - rf_dataOut holds old value.
  - Compute the 2*WIDTH-bit unsigned product old*damping, shift right by FRAC, and add base in WIDTH+1 bits.
  - If the result exceeds 2**WIDTH-1, clamp to all ones and set sat.
  - Register the result → WR.
- WR:
  - rf_writeEnable=1, rf_dest=index, rf_dataIn=result.
  - If index==NODES-1 → IDLE, busy=0, and done=1 for the next single cycle. Otherwise index+1 → RD.
- Timing:
  - 3 cycles per node.
  - With start accepted at edge E0, done is high during the cycle following edge E0+3*NODES.
  - busy is high for exactly 3*NODES cycles.
- start while busy is ignored and not queued.
- Host port:
  - host_gnt = host_req & (state==IDLE) & ~start.
  - When granted, drive rf_writeEnable=host_we, rf_readEnable=~host_we, rf_dest=rf_source=host_addr, rf_dataIn=host_wdata.
  - A granted read raises host_rvalid the next cycle.
  - While busy, host_gnt=0.
- Idle with no grant: all rf_* outputs are 0.
- rf_readEnable and rf_writeEnable are never high in the same cycle from the sweep engine.

Test Plan:
- Nominal node: preload rf[0]=65536 (1.0) via host, damping=55706, base=9830, NODES=1 → rf[0]=65536 after sweep, done 3 cycles after the start edge, sat=0.
- Zero rank: rf[5]=0, NODES=32 → rf[5]=9830; busy high exactly 96 cycles; a single done pulse.
- Saturation: rf[0]=2097151, damping=65536, base=9830 → rf[0]=2097151, sat=1. The next start clears sat.
- Arbitration: host_req held with a read of addr 3 during the sweep → host_gnt=0 until done. Granted the cycle after done; host_rvalid and the correct data the following cycle. start with host_req in the same IDLE cycle → start wins.
- Start while busy at cycle 10 is ignored; the sweep ends at the original cycle, with no second sweep.
- Reset asserted at cycle 20 of a 32-node sweep → busy/done/rf_* go to 0 immediately. Nodes 0..5 are updated and node 6 onward are unchanged. A new start runs a full sweep.

Source files
------------

// File: rtl/pagerank_sweep_ctrl.sv
// PageRank damping sweep controller: read-modify-write of every rank entry with
// new = sat((old * damping) >> FRAC + base), plus an idle-only host access port.
module pagerank_sweep_ctrl #(
    parameter int unsigned WIDTH    = 21,
    parameter int unsigned ADDWIDTH = 5,
    parameter int unsigned NODES    = 32,
    parameter int unsigned FRAC     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    damping,
    input  logic [WIDTH-1:0]    base,
    output logic                busy,
    output logic                done,
    output logic                sat,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDWIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0]    host_wdata,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [WIDTH-1:0]    host_rdata,
    output logic                rf_writeEnable,
    output logic                rf_readEnable,
    output logic [ADDWIDTH-1:0] rf_dest,
    output logic [ADDWIDTH-1:0] rf_source,
    output logic [WIDTH-1:0]    rf_dataIn,
    input  logic [WIDTH-1:0]    rf_dataOut
);

    typedef enum logic [1:0] {StIdle, StRd, StCalc, StWr} state_e;

    localparam logic [ADDWIDTH-1:0] LastIdx = ADDWIDTH'(NODES - 1);

    state_e              state_q, state_d;
    logic [ADDWIDTH-1:0] index_q, index_d;
    logic [WIDTH-1:0]    damping_q, base_q;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                sat_q, sat_d;
    logic                done_q, done_d;
    logic                rvalid_q;
    logic                accept;

    logic [2*WIDTH-1:0]  product;
    logic [2*WIDTH:0]    sum;
    logic                overflow;

    // Full-width datapath so that any bit above WIDTH flags saturation.
    always_comb begin
        product  = (2*WIDTH)'(rf_dataOut) * (2*WIDTH)'(damping_q);
        sum      = {1'b0, product >> FRAC} + (2*WIDTH+1)'(base_q);
        overflow = |sum[2*WIDTH:WIDTH];
    end

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        result_d       = result_q;
        sat_d          = sat_q;
        done_d         = 1'b0;
        host_gnt       = 1'b0;
        rf_writeEnable = 1'b0;
        rf_readEnable  = 1'b0;
        rf_dest        = '0;
        rf_source      = '0;
        rf_dataIn      = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRd;
                    index_d = '0;
                    sat_d   = 1'b0;
                end else if (host_req && reset) begin
                    host_gnt       = 1'b1;
                    rf_writeEnable = host_we;
                    rf_readEnable  = ~host_we;
                    rf_dest        = host_addr;
                    rf_source      = host_addr;
                    rf_dataIn      = host_wdata;
                end
            end
            StRd: begin
                rf_readEnable = 1'b1;
                rf_source     = index_q;
                state_d       = StCalc;
            end
            StCalc: begin
                result_d = overflow ? '1 : sum[WIDTH-1:0];
                if (overflow) begin
                    sat_d = 1'b1;
                end
                state_d = StWr;
            end
            StWr: begin
                rf_writeEnable = 1'b1;
                rf_dest        = index_q;
                rf_dataIn      = result_q;
                if (index_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + ADDWIDTH'(1);
                    state_d = StRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            index_q   <= '0;
            damping_q <= '0;
            base_q    <= '0;
            result_q  <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            rvalid_q <= host_gnt & ~host_we;
            if (accept) begin
                damping_q <= damping;
                base_q    <= base;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign sat         = sat_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rf_dataOut;

endmodule

// File: tb/tb_pagerank_sweep_ctrl.sv
// Bench for pagerank_sweep_ctrl: register-file model, vector table of single-node
// results, a scoreboard of expected sweep writes, and arbitration/reset sequences.
module tb_pagerank_sweep_ctrl;

    localparam int NODES = 32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [20:0] damping, base;
    logic        busy, done, sat;
    logic        host_req, host_we;
    logic [4:0]  host_addr;
    logic [20:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [20:0] host_rdata;
    logic        rf_writeEnable, rf_readEnable;
    logic [4:0]  rf_dest, rf_source;
    logic [20:0] rf_dataIn, rf_dataOut;

    pagerank_sweep_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .damping        (damping),
        .base           (base),
        .busy           (busy),
        .done           (done),
        .sat            (sat),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .rf_writeEnable (rf_writeEnable),
        .rf_readEnable  (rf_readEnable),
        .rf_dest        (rf_dest),
        .rf_source      (rf_source),
        .rf_dataIn      (rf_dataIn),
        .rf_dataOut     (rf_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, registered read that is 0 when not read.
    logic [20:0] mem [NODES];
    initial rf_dataOut = '0;
    always @(posedge clk) begin
        if (rf_writeEnable) mem[rf_dest] <= rf_dataIn;
        rf_dataOut <= rf_readEnable ? mem[rf_source] : 21'd0;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [21:0] model(input logic [20:0] old, input logic [20:0] d,
                                          input logic [20:0] b);
        logic [63:0] r;
        r = ((64'(old) * 64'(d)) >> 16) + 64'(b);
        if (r > 64'd2097151) return {1'b1, 21'h1FFFFF};
        return {1'b0, r[20:0]};
    endfunction

    logic [20:0] exp_mem [NODES];
    logic [20:0] pre_mem [NODES];
    logic        exp_sat;
    logic [25:0] sweep_q [$];
    logic [25:0] sb_exp;

    always @(negedge clk) begin
        if (busy && rf_writeEnable) begin
            check("sweep_rw_exclusive", 64'(rf_readEnable), 0);
            if (sweep_q.size() == 0) begin
                check("sweep_unexpected_write", 64'({rf_dest, rf_dataIn}), 64'h3FFFFFFFFFF);
            end else begin
                sb_exp = sweep_q.pop_front();
                check("sweep_write", 64'({rf_dest, rf_dataIn}), 64'(sb_exp));
            end
        end
    end

    task automatic prep_sweep(input logic [20:0] d, input logic [20:0] b);
        logic [21:0] m;
        pre_mem = exp_mem;
        exp_sat = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            m          = model(exp_mem[i], d, b);
            exp_sat    = exp_sat | m[21];
            exp_mem[i] = m[20:0];
            sweep_q.push_back({5'(i), m[20:0]});
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [20:0] d);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        n = 0;
        while (!host_gnt && n < 200) begin @(negedge clk); #1; n++; end
        check("wr_gnt", 64'(host_gnt), 1);
        @(posedge clk);
        #1 host_req = 1'b0; host_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [20:0] d);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        n = 0;
        while (!host_gnt && n < 200) begin @(negedge clk); #1; n++; end
        check("rd_gnt", 64'(host_gnt), 1);
        @(posedge clk);
        #1 host_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 64'(host_rvalid), 1);
        d = host_rdata;
    endtask

    // restart_at: cycle to pulse start while busy; reset_at: cycle to assert reset (0 = none).
    task automatic run_sweep(input logic [20:0] d, input logic [20:0] b,
                             input int restart_at, input int reset_at);
        int done_at, busy_cnt, done_cnt;
        @(negedge clk);
        start = 1'b1; damping = d; base = b;
        prep_sweep(d, b);
        @(posedge clk);
        done_at = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 3*NODES + 4; k++) begin
            @(negedge clk);
            if (k == 1) check("sat_cleared_on_start", 64'(sat), 0);
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 0);
                check("rst_done", 64'(done), 0);
                check("rst_sat", 64'(sat), 0);
                check("rst_rf_ctrl", 64'({rf_writeEnable, rf_readEnable}), 0);
                check("rst_rf_bus", 64'({rf_dest, rf_source, rf_dataIn}), 0);
                sweep_q.delete();
                for (int i = (reset_at - 1) / 3; i < NODES; i++) exp_mem[i] = pre_mem[i];
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                return;
            end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = k; end
            start = (k == restart_at);
        end
        start = 1'b0;
        check("done_latency", 64'(done_at), 64'(3*NODES + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(3*NODES));
        check("done_pulses", 64'(done_cnt), 1);
        check("sat_flag", 64'(sat), 64'(exp_sat));
        check("scoreboard_drained", 64'(sweep_q.size()), 0);
    endtask

    typedef struct {
        logic [20:0] old;
        logic [20:0] damp;
        logic [20:0] base;
        logic [20:0] exp;
        logic        sat;
    } vec_t;

    vec_t        vecs [8];
    logic [20:0] rd;
    int          gnt_bad;
    logic        got_done;

    initial begin
        vecs[0] = '{21'd65536,   21'd55706,  21'd9830,    21'd65536,   1'b0};
        vecs[1] = '{21'd0,       21'd55706,  21'd9830,    21'd9830,    1'b0};
        vecs[2] = '{21'd2097151, 21'd65536,  21'd9830,    21'd2097151, 1'b1};
        vecs[3] = '{21'd131072,  21'd55706,  21'd0,       21'd111412,  1'b0};
        vecs[4] = '{21'd2097151, 21'd131072, 21'd0,       21'd2097151, 1'b1};
        vecs[5] = '{21'd100000,  21'd32768,  21'd2097100, 21'd2097151, 1'b1};
        vecs[6] = '{21'd12345,   21'd65536,  21'd0,       21'd12345,   1'b0};
        vecs[7] = '{21'd2097151, 21'd0,      21'd2097151, 21'd2097151, 1'b0};

        reset = 1'b0; start = 1'b0; damping = '0; base = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #12;
        check("reset_status", 64'({busy, done, sat, host_rvalid, host_gnt}), 0);
        check("reset_rf_ctrl", 64'({rf_writeEnable, rf_readEnable}), 0);
        check("reset_rf_bus", 64'({rf_dest, rf_source, rf_dataIn}), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NODES; i++) host_write(5'(i), 21'd0);
            host_write(5'd0, vecs[v].old);
            run_sweep(vecs[v].damp, vecs[v].base, 0, 0);
            host_read(5'd0, rd);
            check("vec_rank", 64'(rd), 64'(vecs[v].exp));
            check("vec_sat", 64'(sat), 64'(vecs[v].sat));
        end

        // Zero rank in the middle of a full sweep.
        host_write(5'd5, 21'd0);
        run_sweep(21'd55706, 21'd9830, 0, 0);
        host_read(5'd5, rd);
        check("zero_rank", 64'(rd), 64'd9830);

        // start and host_req together: start wins; read held through the sweep.
        host_write(5'd3, 21'd200000);
        @(negedge clk);
        start = 1'b1; damping = 21'd55706; base = 21'd9830;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
        #1;
        check("start_beats_host", 64'(host_gnt), 0);
        prep_sweep(21'd55706, 21'd9830);
        @(posedge clk);
        gnt_bad = 0; got_done = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (busy && host_gnt) gnt_bad++;
            if (done) begin
                got_done = 1'b1;
                check("gnt_after_done", 64'(host_gnt), 1);
                break;
            end
        end
        check("gnt_while_busy", 64'(gnt_bad), 0);
        check("arb_done_seen", 64'(got_done), 1);
        @(posedge clk);
        #1 host_req = 1'b0;
        @(negedge clk);
        check("arb_rvalid", 64'(host_rvalid), 1);
        check("arb_rdata", 64'(host_rdata), 64'd179831);

        // start while busy is dropped.
        run_sweep(21'd55706, 21'd9830, 10, 0);

        // Reset mid-sweep: nodes 0..5 updated, 6 onward untouched.
        host_write(5'd5, 21'd0);
        host_write(5'd6, 21'd0);
        run_sweep(21'd55706, 21'd9830, 0, 20);
        host_read(5'd5, rd);
        check("rst_node5_updated", 64'(rd), 64'd9830);
        host_read(5'd6, rd);
        check("rst_node6_unchanged", 64'(rd), 64'd0);
        run_sweep(21'd55706, 21'd9830, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
